uart_rx_ext: RTL

Parametrised next-generation UART receiver. Adds runtime data length (5..DATA_W bits), optional parity and a valid/ready output holding register, and reports overrun, parity and framing errors. Sits between the synchronised pad input and the register/FIFO layer of the UART controller. One instance per channel.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_tick.sv | 43 ++++
 rtl/uart_rx_ext.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx_ext receiver.
package uart_rx_pkg;

  localparam int unsigned MAX_DATA_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  perr;
    logic                  ferr;
    logic                  brk;
  } frame_t;

  function automatic logic vote3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick prescaler and bit-phase counter with sample/bit-end strobes.
module uart_rx_tick #(
  parameter int unsigned OSR = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        samp0,
  output logic        samp1,
  output logic        samp2,
  output logic        bit_end
);

  localparam int unsigned PW = $clog2(OSR);

  logic [15:0]   pre;
  logic [PW-1:0] ph;
  logic          tick;

  assign tick = (pre == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      ph  <= '0;
    end else if (clr) begin
      pre <= '0;
      ph  <= '0;
    end else if (tick) begin
      pre <= '0;
      ph  <= (ph == PW'(OSR - 1)) ? '0 : ph + 1'b1;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  assign samp0   = tick && (ph == PW'(OSR / 2 - 2));
  assign samp1   = tick && (ph == PW'(OSR / 2));
  assign samp2   = tick && (ph == PW'(OSR / 2 + 2));
  assign bit_end = tick && (ph == PW'(OSR - 1));

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with runtime frame format and valid/ready holding register.
// Define UART_RX_BREAK_EN to add rx_break and hold-off re-arm after a break.
module uart_rx_ext
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OSR    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cfg_div,
  input  logic              cfg_rxen,
  input  logic [3:0]        cfg_dbits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_nstop,
  input  logic              uart_rxd,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              rx_overrun
`ifdef UART_RX_BREAK_EN
  ,output logic             rx_break
`endif
);

  state_t state, state_d;

  logic              sync1, rxd_s;
  logic              samp0, samp1, samp2, bit_end;
  logic [2:0]        samp;
  logic              vote, start_det, armed, done, load;
  logic [3:0]        dbits_cfg, dbits_l, bitcnt;
  logic              par_en_l, par_odd_l, nstop_l, stop_idx;
  logic [DATA_W-1:0] shreg;
  logic              perr_acc, ferr_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      rxd_s <= sync1;
    end
  end

  assign vote      = vote3(samp);
  assign start_det = (state == IDLE) && !rxd_s && cfg_rxen && armed;
  assign dbits_cfg = (cfg_dbits < 4'd5 || cfg_dbits > 4'(DATA_W)) ? 4'(DATA_W) : cfg_dbits;

  uart_rx_tick #(.OSR(OSR)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_det),
    .div     (cfg_div),
    .samp0   (samp0),
    .samp1   (samp1),
    .samp2   (samp2),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    done    = 1'b0;
    if (state != IDLE && !cfg_rxen) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_det) state_d = START;
        START:   if (bit_end) state_d = vote ? IDLE : DATA;
        DATA:    if (bit_end && bitcnt == dbits_l - 4'd1) state_d = par_en_l ? PARITY : STOP;
        PARITY:  if (bit_end) state_d = STOP;
        STOP: begin
          if (bit_end && stop_idx == nstop_l) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp      <= '0;
      dbits_l   <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      nstop_l   <= 1'b0;
      bitcnt    <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      perr_acc  <= 1'b0;
      ferr_acc  <= 1'b0;
    end else begin
      if (samp0) samp[0] <= rxd_s;
      if (samp1) samp[1] <= rxd_s;
      if (samp2) samp[2] <= rxd_s;
      if (start_det) begin
        dbits_l   <= dbits_cfg;
        par_en_l  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
        par_odd_l <= (cfg_parity == PAR_ODD);
        nstop_l   <= cfg_nstop;
        bitcnt    <= '0;
        stop_idx  <= 1'b0;
        shreg     <= '0;
        perr_acc  <= 1'b0;
        ferr_acc  <= 1'b0;
      end else if (bit_end) begin
        case (state)
          DATA: begin
            shreg  <= shreg | (DATA_W'(vote) << bitcnt);
            bitcnt <= bitcnt + 4'd1;
          end
          PARITY: perr_acc <= vote ^ (^shreg) ^ par_odd_l;
          STOP: begin
            ferr_acc <= ferr_acc | ~vote;
            stop_idx <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A completing frame may load in the same cycle the consumer drains the old one.
  assign load = done && (!rx_valid || rx_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= done && rx_valid && !rx_ready;
      if (load) begin
        rx_valid <= 1'b1;
        rx_data  <= shreg;
        rx_perr  <= perr_acc;
        rx_ferr  <= ferr_acc | ~vote;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_EN
  logic zero_acc, brk_acc, wait_high, brk_now;

  assign brk_now = stop_idx ? brk_acc : (zero_acc & ~vote);
  assign armed   = ~wait_high;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_acc  <= 1'b0;
      brk_acc   <= 1'b0;
      wait_high <= 1'b0;
      rx_break  <= 1'b0;
    end else begin
      if (start_det) begin
        zero_acc <= 1'b1;
      end else if (bit_end && (state == DATA || state == PARITY)) begin
        zero_acc <= zero_acc & ~vote;
      end else if (bit_end && state == STOP && !stop_idx) begin
        brk_acc <= zero_acc & ~vote;
      end
      if (done && brk_now) wait_high <= 1'b1;
      else if (rxd_s)      wait_high <= 1'b0;
      if (load) rx_break <= brk_now;
    end
  end
`else
  assign armed = 1'b1;
`endif

endmodule
